fsm_table_engine: RTL and testbench



---
 rtl/fsm_table_engine_pkg.sv | 47 ++++
 rtl/fsm_table_engine_if.sv | 26 ++
 rtl/fsm_table_engine_store.sv | 58 +++++
 rtl/fsm_table_engine.sv | 68 ++++++
 tb/tb_fsm_table_engine.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fsm_table_engine_pkg.sv
// rtl/fsm_table_engine_pkg.sv - state encodings, table entry type and default lab table
package fsm_table_pkg;

  localparam int ENTRY_FIELD_W = 8;

  localparam logic [2:0] A_ST = 3'd0;
  localparam logic [2:0] B_ST = 3'd1;
  localparam logic [2:0] C_ST = 3'd2;
  localparam logic [2:0] D_ST = 3'd3;
  localparam logic [2:0] E_ST = 3'd4;

  typedef struct packed {
    logic [ENTRY_FIELD_W-1:0] next;
    logic [ENTRY_FIELD_W-1:0] out;
  } fsm_entry_t;

  function automatic fsm_entry_t mk(input logic [2:0] nxt, input logic o);
    fsm_entry_t e;
    e.next = {5'd0, nxt};
    e.out  = {7'd0, o};
    return e;
  endfunction

  // The lab machine only exists for a 1-bit input; everything else parks in reset state.
  function automatic fsm_entry_t default_entry(input int idx, input int in_w, input int reset_state);
    fsm_entry_t e;
    e.next = ENTRY_FIELD_W'(reset_state);
    e.out  = '0;
    if (in_w == 1) begin
      case (idx)
        0: e = mk(D_ST, 1'b0);
        1: e = mk(E_ST, 1'b1);
        2: e = mk(B_ST, 1'b0);
        3: e = mk(E_ST, 1'b1);
        4: e = mk(C_ST, 1'b0);
        5: e = mk(A_ST, 1'b1);
        6: e = mk(B_ST, 1'b0);
        7: e = mk(C_ST, 1'b1);
        8: e = mk(C_ST, 1'b0);
        9: e = mk(D_ST, 1'b0);
        default: ;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/fsm_table_engine_if.sv
// rtl/fsm_table_engine_if.sv - step/input/output and table config signals of the engine
interface fsm_table_engine_if #(
  parameter int STATE_W = 3,
  parameter int IN_W    = 1,
  parameter int OUT_W   = 1
);
  logic                    en;
  logic [IN_W-1:0]         x;
  logic [OUT_W-1:0]        y;
  logic [STATE_W-1:0]      state;
  logic                    cfg_we;
  logic [STATE_W+IN_W-1:0] cfg_addr;
  logic [STATE_W-1:0]      cfg_next;
  logic [OUT_W-1:0]        cfg_out;
  logic                    cfg_err;

  modport master (
    output en, x, cfg_we, cfg_addr, cfg_next, cfg_out,
    input  y, state, cfg_err
  );

  modport slave (
    input  en, x, cfg_we, cfg_addr, cfg_next, cfg_out,
    output y, state, cfg_err
  );
endinterface

// File: rtl/fsm_table_engine_store.sv
// rtl/fsm_table_engine_store.sv - register-file transition table with reset defaults and checked writes
module fsm_table_store
  import fsm_table_pkg::*;
#(
  parameter int N_STATES    = 5,
  parameter int STATE_W     = 3,
  parameter int IN_W        = 1,
  parameter int OUT_W       = 1,
  parameter int RESET_STATE = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [STATE_W+IN_W-1:0] waddr,
  input  logic [STATE_W-1:0]      wnext,
  input  logic [OUT_W-1:0]        wout,
  input  logic [STATE_W+IN_W-1:0] raddr,
  output logic [STATE_W-1:0]      rnext,
  output logic [OUT_W-1:0]        rout,
  output logic                    err
);
  localparam int ADDR_W = STATE_W + IN_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [STATE_W-1:0] next_mem [DEPTH];
  logic [OUT_W-1:0]   out_mem  [DEPTH];
  logic [STATE_W-1:0] def_next [DEPTH];
  logic [OUT_W-1:0]   def_out  [DEPTH];
  logic               valid;

  for (genvar g = 0; g < DEPTH; g++) begin : g_def
    localparam fsm_entry_t DEF = default_entry(g, IN_W, RESET_STATE);
    assign def_next[g] = DEF.next[STATE_W-1:0];
    assign def_out[g]  = DEF.out[OUT_W-1:0];
  end

  assign valid = (int'(waddr[ADDR_W-1:IN_W]) < N_STATES) && (int'(wnext) < N_STATES);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        next_mem[i] <= def_next[i];
        out_mem[i]  <= def_out[i];
      end
      err <= 1'b0;
    end else begin
      err <= we && !valid;
      if (we && valid) begin
        next_mem[waddr] <= wnext;
        out_mem[waddr]  <= wout;
      end
    end
  end

  // Read is asynchronous, so a same-edge write is only seen from the next cycle.
  assign rnext = next_mem[raddr];
  assign rout  = out_mem[raddr];
endmodule

// File: rtl/fsm_table_engine.sv
// rtl/fsm_table_engine.sv - table-driven Mealy FSM; FSM_TABLE_ENGINE_REG_OUT_EN registers y
module fsm_table_engine
  import fsm_table_pkg::*;
#(
  parameter int N_STATES    = 5,
  parameter int STATE_W     = 3,
  parameter int IN_W        = 1,
  parameter int OUT_W       = 1,
  parameter int RESET_STATE = 0
) (
  input logic clock,
  input logic reset,
  fsm_table_engine_if.slave bus
);
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] e_next;
  logic [OUT_W-1:0]   e_out;
  logic [STATE_W-1:0] nxt;
  logic [OUT_W-1:0]   y_comb;
  logic               illegal;

  fsm_table_store #(
    .N_STATES(N_STATES), .STATE_W(STATE_W), .IN_W(IN_W),
    .OUT_W(OUT_W), .RESET_STATE(RESET_STATE)
  ) u_store (
    .clock (clock),
    .reset (reset),
    .we    (bus.cfg_we),
    .waddr (bus.cfg_addr),
    .wnext (bus.cfg_next),
    .wout  (bus.cfg_out),
    .raddr ({state_q, bus.x}),
    .rnext (e_next),
    .rout  (e_out),
    .err   (bus.cfg_err)
  );

  // Out-of-range state (upset/force only) is steered home with a quiet output.
  assign illegal = int'(state_q) >= N_STATES;
  assign nxt     = illegal ? STATE_W'(RESET_STATE) : e_next;
  assign y_comb  = illegal ? '0 : e_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= STATE_W'(RESET_STATE);
    end else if (bus.en) begin
      state_q <= nxt;
    end
  end

  assign bus.state = state_q;

`ifdef FSM_TABLE_ENGINE_REG_OUT_EN
  logic [OUT_W-1:0] y_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      y_q <= '0;
    end else if (bus.en) begin
      y_q <= y_comb;
    end
  end

  assign bus.y = y_q;
`else
  assign bus.y = y_comb;
`endif
endmodule

// File: tb/tb_fsm_table_engine.sv
// tb/tb_fsm_table_engine.sv - directed lab scenarios plus randomized run against a table model
module tb_fsm_table_engine;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic chk_on = 1'b0;

  // Model: lab machine written as a transition table indexed state*2+x.
  int def_next [10] = '{3, 4, 1, 4, 2, 0, 1, 2, 2, 3};
  int def_out  [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
  int m_next [16];
  int m_out  [16];
  int m_state = 0;
  int m_y     = 0;
  int m_err   = 0;

  int y1  [4] = '{1, 0, 1, 1};
  int yr1 [4] = '{0, 1, 0, 1};
  int st1 [4] = '{4, 3, 2, 0};
  int st2 [3] = '{3, 1, 1};

  fsm_table_engine_if #(.STATE_W(3), .IN_W(1), .OUT_W(1)) bus ();

  fsm_table_engine #(
    .N_STATES(5), .STATE_W(3), .IN_W(1), .OUT_W(1), .RESET_STATE(0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load_defaults();
    for (int i = 0; i < 16; i++) begin
      m_next[i] = (i < 10) ? def_next[i] : 0;
      m_out[i]  = (i < 10) ? def_out[i] : 0;
    end
  endtask

  function automatic int exp_y();
`ifdef FSM_TABLE_ENGINE_REG_OUT_EN
    return m_y;
`else
    return (m_state < 5) ? m_out[m_state * 2 + int'(bus.x)] : 0;
`endif
  endfunction

  task automatic tick();
    int idx;
    int a_st;
    @(posedge clock);
    if (reset) begin
      m_state = 0;
      m_y     = 0;
      m_err   = 0;
      load_defaults();
    end else begin
      idx = m_state * 2 + int'(bus.x);
      if (bus.en) begin
        m_y     = (m_state < 5) ? m_out[idx] : 0;
        m_state = (m_state < 5) ? m_next[idx] : 0;
      end
      a_st  = int'(bus.cfg_addr) / 2;
      m_err = (bus.cfg_we && (a_st >= 5 || int'(bus.cfg_next) >= 5)) ? 1 : 0;
      if (bus.cfg_we && m_err == 0) begin
        m_next[int'(bus.cfg_addr)] = int'(bus.cfg_next);
        m_out[int'(bus.cfg_addr)]  = int'(bus.cfg_out);
      end
    end
    #1;
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      chk("state", int'(bus.state), m_state);
      chk("y", int'(bus.y), exp_y());
      chk("cfg_err", int'(bus.cfg_err), m_err);
    end
  end

  initial begin
    bus.en = 1'b0; bus.x = 1'b0; bus.cfg_we = 1'b0;
    bus.cfg_addr = '0; bus.cfg_next = '0; bus.cfg_out = '0;
    load_defaults();
    repeat (2) tick();
    reset = 1'b0;
    chk_on = 1'b1;

    // Lab sequence x=1,1,1,1 from reset.
    bus.en = 1'b1; bus.x = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
`ifdef FSM_TABLE_ENGINE_REG_OUT_EN
      chk("s1_y", int'(bus.y), yr1[i]);
`else
      chk("s1_y", int'(bus.y), y1[i]);
`endif
      tick();
      chk("s1_state", int'(bus.state), st1[i]);
    end
`ifdef FSM_TABLE_ENGINE_REG_OUT_EN
    chk("s1_y_last", int'(bus.y), 1);
`endif

    // x=0 from reset.
    reset = 1'b1; tick(); reset = 1'b0;
    bus.x = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_state", int'(bus.state), st2[i]);
      chk("s2_y", int'(bus.y), 0);
    end

    // Hold in state 2 with en low.
    reset = 1'b1; tick(); reset = 1'b0;
    bus.x = 1'b1;
    repeat (3) tick();
    chk("s3_reach", int'(bus.state), 2);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s3_hold_state", int'(bus.state), 2);
      chk("s3_hold_y", int'(bus.y), 1);
    end
    bus.en = 1'b1;
    tick();
    chk("s3_release", int'(bus.state), 0);

    // Reprogram a/x1 -> c/0.
    bus.en = 1'b0; bus.x = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd1; bus.cfg_next = 3'd2; bus.cfg_out = 1'b0;
    tick();
    bus.cfg_we = 1'b0;
    chk("s4_err_ok", int'(bus.cfg_err), 0);
    bus.en = 1'b1; bus.x = 1'b1;
`ifndef FSM_TABLE_ENGINE_REG_OUT_EN
    #2;
    chk("s4_y", int'(bus.y), 0);
`endif
    tick();
    chk("s4_state", int'(bus.state), 2);
`ifdef FSM_TABLE_ENGINE_REG_OUT_EN
    chk("s4_y_reg", int'(bus.y), 0);
`endif

    // Rejected writes: bad state field, then bad next field.
    bus.en = 1'b0;
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd12; bus.cfg_next = 3'd1;
    tick();
    bus.cfg_we = 1'b0;
    chk("s4_err_pulse", int'(bus.cfg_err), 1);
    tick();
    chk("s4_err_clear", int'(bus.cfg_err), 0);
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd4; bus.cfg_next = 3'd7;
    tick();
    bus.cfg_we = 1'b0;
    chk("s4_err_next", int'(bus.cfg_err), 1);
    bus.en = 1'b1; bus.x = 1'b0;
    tick();
    chk("s4_c_x0_kept", int'(bus.state), 2);

    // Reset with a simultaneous write: write lost, defaults back.
    reset = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_addr = 4'd1; bus.cfg_next = 3'd3; bus.cfg_out = 1'b0;
    tick();
    reset = 1'b0; bus.cfg_we = 1'b0;
    chk("s5_state", int'(bus.state), 0);
    bus.x = 1'b1;
`ifndef FSM_TABLE_ENGINE_REG_OUT_EN
    #2;
    chk("s5_y", int'(bus.y), 1);
`endif
    tick();
    chk("s5_next", int'(bus.state), 4);
`ifdef FSM_TABLE_ENGINE_REG_OUT_EN
    chk("s5_y_reg", int'(bus.y), 1);
`endif

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.x        = 1'($urandom_range(0, 1));
      bus.cfg_we   = ($urandom_range(0, 5) == 0);
      bus.cfg_addr = 4'($urandom_range(0, 15));
      bus.cfg_next = 3'($urandom_range(0, 7));
      bus.cfg_out  = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b0;
    bus.cfg_we = 1'b0;
    tick();
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
